nand_resp_checker: RTL and testbench

NAND_RESP_CHECKER -- requirements
Module: nand_resp_checker

---
 rtl/nand_resp_checker.sv | 170 +++++++++++++++++
 tb/tb_nand_resp_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nand_resp_checker.sv
// Response checker for a single NAND stage: waits for {a,b} to settle, samples dut_out,
// and counts mismatches. Define NAND_CHK_FIRSTFAIL_EN to capture the first failing vector.
module nand_resp_checker #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             a,
  input  logic             b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_vec,
  output logic [1:0]       first_fail_ab
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_SAMPLE   = 3'd2,
    S_WAIT_CHG = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [1:0]       prev_ab_r;
  logic [7:0]       settle_cnt_r;
  logic [CNT_W-1:0] num_lat_r;

  logic [1:0]       ab_s;
  logic             ab_chg_s;
  logic             mismatch_s;
  logic             err_full_s;
  logic [CNT_W-1:0] vec_inc_s;

  function automatic logic nand_exp(input logic x, input logic y);
    return ~(x & y);
  endfunction

  // Change detection against the previous cycle and the sample comparison.
  always_comb begin
    ab_s       = {a, b};
    ab_chg_s   = (ab_s != prev_ab_r);
    // Case inequality so that X/Z on dut_out counts as a mismatch in simulation
    mismatch_s = (dut_out !== nand_exp(a, b));
    err_full_s = &err_cnt;
    vec_inc_s  = vec_cnt + CNT_ONE;
  end

  // Checker FSM with registered status outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      prev_ab_r      <= 2'b00;
      settle_cnt_r   <= 8'd0;
      num_lat_r      <= CNT_ZERO;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      vec_cnt        <= CNT_ZERO;
      err_cnt        <= CNT_ZERO;
`ifdef NAND_CHK_FIRSTFAIL_EN
      first_fail_vec <= CNT_ZERO;
      first_fail_ab  <= 2'b00;
`endif
    end else begin
      prev_ab_r <= ab_s;
      if (abort) begin
        state_r <= S_IDLE;
        busy    <= 1'b0;
        done    <= 1'b0;
        pass    <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE, S_DONE: begin
            if (start) begin
              vec_cnt        <= CNT_ZERO;
              err_cnt        <= CNT_ZERO;
              settle_cnt_r   <= 8'd0;
              num_lat_r      <= num_vec;
`ifdef NAND_CHK_FIRSTFAIL_EN
              first_fail_vec <= CNT_ZERO;
              first_fail_ab  <= 2'b00;
`endif
              if (num_vec == CNT_ZERO) begin
                state_r <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b1;
              end else begin
                state_r <= S_SETTLE;
                busy    <= 1'b1;
                done    <= 1'b0;
                pass    <= 1'b0;
              end
            end else begin
              state_r <= state_r;
            end
          end
          S_SETTLE: begin
            if (ab_chg_s) begin
              settle_cnt_r <= 8'd0;
            end else if (settle_cnt_r == SETTLE_LAST) begin
              state_r <= S_SAMPLE;
            end else begin
              settle_cnt_r <= settle_cnt_r + 8'd1;
            end
          end
          S_SAMPLE: begin
            vec_cnt <= vec_inc_s;
            if (mismatch_s && !err_full_s) begin
              err_cnt <= err_cnt + CNT_ONE;
            end else begin
              err_cnt <= err_cnt;
            end
`ifdef NAND_CHK_FIRSTFAIL_EN
            // err_cnt still zero means this is the first mismatch of the run
            if (mismatch_s && (err_cnt == CNT_ZERO)) begin
              first_fail_vec <= vec_cnt;
              first_fail_ab  <= ab_s;
            end else begin
              first_fail_vec <= first_fail_vec;
            end
`endif
            if (vec_inc_s == num_lat_r) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_cnt == CNT_ZERO) && !mismatch_s;
            end else begin
              state_r <= S_WAIT_CHG;
            end
          end
          S_WAIT_CHG: begin
            // prev_ab_r holds the sampled value until the first change arrives
            if (ab_chg_s) begin
              state_r      <= S_SETTLE;
              settle_cnt_r <= 8'd0;
            end else begin
              state_r <= S_WAIT_CHG;
            end
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef NAND_CHK_FIRSTFAIL_EN
  assign first_fail_vec = CNT_ZERO;
  assign first_fail_ab  = 2'b00;
`endif

endmodule

// File: tb/tb_nand_resp_checker.sv
// Scoreboard bench for nand_resp_checker (CNT_W=4, SETTLE_CYC=2): run results are
// predicted when stimulus is issued and compared when done rises.
module tb_nand_resp_checker;

  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] vec;
    logic [CW-1:0] err;
    logic          pass;
    logic [CW-1:0] ffv;
    logic [1:0]    ffab;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, a, b, dut_out;
  logic [CW-1:0] num_vec;
  logic          busy, done, pass;
  logic [CW-1:0] vec_cnt, err_cnt, first_fail_vec;
  logic [1:0]    first_fail_ab;

  logic [1:0]    mode;
  logic [1:0]    vec_tab [0:15];
  exp_t          sb_q [$];
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  nand_resp_checker #(.CNT_W(CW), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .a(a), .b(b), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_fail_vec(first_fail_vec),
    .first_fail_ab(first_fail_ab)
  );

  // Stage under test: 0 ideal NAND, 1 stuck at 1, 2 stuck at 0
  function automatic logic model_out(input logic [1:0] md, input logic [1:0] ab);
    case (md)
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return ~(ab[1] & ab[0]);
    endcase
  endfunction

  always_comb dut_out = model_out(mode, {a, b});

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic run_vecs(input logic [1:0] md, input int n, input string tag);
    exp_t e;
    logic [CW-1:0] err;
    e = '0;
    err = '0;
    for (int i = 0; i < n; i++) begin
      if (model_out(md, vec_tab[i]) != ~(vec_tab[i][1] & vec_tab[i][0])) begin
        if (err == 4'd0) begin
          e.ffv  = 4'(i);
          e.ffab = vec_tab[i];
        end
        if (err != 4'hf) err++;
      end
    end
    e.vec  = 4'(n);
    e.err  = err;
    e.pass = (err == 4'd0);
`ifndef NAND_CHK_FIRSTFAIL_EN
    e.ffv  = '0;
    e.ffab = '0;
`endif
    sb_q.push_back(e);
    @(negedge clk);
    mode = md;
    {a, b} = vec_tab[0];
    num_vec = 4'(n);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < n; i++) begin
      repeat (10) @(negedge clk);
      {a, b} = vec_tab[i];
    end
    for (int k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    e = sb_q.pop_front();
    check_val({tag, "_vec_cnt"}, 32'(vec_cnt), 32'(e.vec));
    check_val({tag, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
    check_val({tag, "_pass"}, 32'(pass), 32'(e.pass));
    check_val({tag, "_ff_vec"}, 32'(first_fail_vec), 32'(e.ffv));
    check_val({tag, "_ff_ab"}, 32'(first_fail_ab), 32'(e.ffab));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_pass"}, 32'(pass), 32'd0);
    check_val({tag, "_vec_cnt"}, 32'(vec_cnt), 32'd0);
    check_val({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check_val({tag, "_ff_vec"}, 32'(first_fail_vec), 32'd0);
    check_val({tag, "_ff_ab"}, 32'(first_fail_ab), 32'd0);
  endtask

  task automatic fill_basic();
    vec_tab[0] = 2'b00; vec_tab[1] = 2'b01; vec_tab[2] = 2'b10; vec_tab[3] = 2'b11;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = 1'b0; b = 1'b0;
    num_vec = '0; mode = 2'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fill_basic();
    run_vecs(2'd0, 4, "ideal");
    run_vecs(2'd1, 4, "stuck1");

    // Rapid toggling: one sample, three cycles after the last change
    @(negedge clk);
    mode = 2'd0; {a, b} = 2'b00;
    @(negedge clk);
    start = 1'b1; num_vec = 4'd1; {a, b} = 2'b01;
    @(negedge clk); start = 1'b0; {a, b} = 2'b10;
    @(negedge clk); {a, b} = 2'b11;
    @(negedge clk); {a, b} = 2'b00;
    @(negedge clk); {a, b} = 2'b01;
    repeat (3) @(negedge clk);
    check_val("toggle_busy_pre", 32'(busy), 32'd1);
    check_val("toggle_vec_pre", 32'(vec_cnt), 32'd0);
    @(negedge clk);
    check_val("toggle_vec_at", 32'(vec_cnt), 32'd1);
    check_val("toggle_done_at", 32'(done), 32'd1);
    repeat (5) @(negedge clk);
    check_val("toggle_vec_hold", 32'(vec_cnt), 32'd1);

    // Abort in SETTLE after two vectors, with start in the same cycle
    @(negedge clk);
    {a, b} = 2'b00; mode = 2'd0; num_vec = 4'd4;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk); {a, b} = 2'b01;
    repeat (5) @(negedge clk); {a, b} = 2'b10;
    @(negedge clk);
    check_val("abort_busy_pre", 32'(busy), 32'd1);
    check_val("abort_vec_pre", 32'(vec_cnt), 32'd2);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_vec", 32'(vec_cnt), 32'd2);
    repeat (2) @(negedge clk);
    check_val("abort_busy_hold", 32'(busy), 32'd0);
    check_val("abort_vec_hold", 32'(vec_cnt), 32'd2);

    // Every vector fails: err_cnt reaches all-ones without wrapping
    for (int i = 0; i < 15; i++) vec_tab[i] = 2'(i % 3);
    run_vecs(2'd2, 15, "sat");

    @(negedge clk); num_vec = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("zero_done", 32'(done), 32'd1);
    check_val("zero_pass", 32'(pass), 32'd1);
    check_val("zero_busy", 32'(busy), 32'd0);
    check_val("zero_vec", 32'(vec_cnt), 32'd0);
    check_val("zero_err", 32'(err_cnt), 32'd0);

    // Reset in WAIT_CHG, then a fresh run
    @(negedge clk); mode = 2'd2; {a, b} = 2'b00; num_vec = 4'd4;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("mid_vec", 32'(vec_cnt), 32'd1);
    check_val("mid_err", 32'(err_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk); rst_n = 1'b1;
    fill_basic();
    run_vecs(2'd0, 4, "fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
